cnt_datapath: RTL
=================

Name: cnt_datapath

Overview:
- Registered datapath of the mod-31 up/down counter (0..30).
- Consumes the 2-bit next-state select from the boundary detector stage. Sel 2'b10 means wrap; 2'b01 means step.
- Drives the current count back to that detector, closing the loop.
- Adds enable, synchronous load, a wrap pulse, a wrap counter, and a sticky consistency check on the incoming select.

Parameters:
- WIDTH, 5, count width.
- MAXV, 30, terminal count in up mode and wrap target in down mode.
- WCNT_W, 8, width of the wrap event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- mode  input  1  direction: 0 = up, 1 = down.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- sel  input  2  next-state select from boundary detector: 2'b10 = wrap, 2'b01 = step.
- a  output  WIDTH  current count, fed to boundary detector.
- wrap_pulse  output  1  registered 1-cycle pulse on each wrap.
- wrap_cnt  output  WCNT_W  number of wraps since reset or load, saturating.
- sel_err  output  1  sticky: sel disagreed with locally computed select, or was illegal.
- load_clamped  output  1  registered 1-cycle pulse when load_val > MAXV.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a = 0, wrap_cnt = 0, wrap_pulse = 0, sel_err = 0, load_clamped = 0.
  - All outputs hold these values while rst_n is low.
  - Release is synchronous to the next clk edge.
- Priority per rising edge: load > en > hold.
- Load:
  - a <= min(load_val, MAXV).
  - wrap_cnt <= 0.
  - load_clamped <= (load_val > MAXV).
  - wrap_pulse <= 0.
  - sel is ignored that cycle.
- en = 1 and load = 0:
  - sel == 2'b10 and mode == 0: a <= 0.
  - sel == 2'b10 and mode == 1: a <= MAXV.
  - In both wrap cases: wrap_pulse <= 1 and wrap_cnt <= wrap_cnt + 1, saturating at all-ones.
  - sel == 2'b01: a <= a + 1 (mode 0) or a - 1 (mode 1), WIDTH-bit arithmetic. wrap_pulse <= 0.
  - sel == 2'b00 or 2'b11 (illegal): a holds, wrap_pulse <= 0, sel_err <= 1.
- en = 0 and load = 0: a and wrap_cnt hold; wrap_pulse <= 0. sel is not checked.
- Consistency check, evaluated whenever en = 1 and load = 0:
  - Expected select = 2'b10 when (mode == 0 and a == MAXV) or (mode == 1 and a == 0); otherwise 2'b01.
  - If sel differs from expected, sel_err <= 1.
  - Datapath still obeys sel, so the fault is visible. Result matches the detector exactly when the detector is correct.
- sel_err clears only on reset.
- Latency: one cycle from sel/en to a. a is registered only; no combinational path from any input to any output.
- Mode change: sampled every edge. Direction reverses on the first enabled edge after mode changes. At a == 0 with mode switching 1->0, the next step is to 1 (sel = 01), not a wrap.
- Out-of-range state (a > MAXV) is unreachable via load (clamped). The expected-select logic treats it as step.
- Simultaneous load and en: load wins; no wrap is counted.
- Reset mid-operation: immediate return to reset values regardless of clk.

Decomposition:
- Shared package cnt_pkg:
  - SEL_WRAP = 2'b10, SEL_STEP = 2'b01.
  - Default MAXV.
  - The mode encodings MODE_UP = 0, MODE_DN = 1.
  - Shared with the boundary detector.
- One sub-module, cnt_next: combinational next-value and expected-select computation from a, mode, sel. Instantiated once; reused by the verification model.
- Registers stay in cnt_datapath.

Test Plan:
- Reset, then en = 1, mode = 0, sel from a golden detector for 31 cycles -> a runs 0..30 then 0; wrap_pulse high exactly on the cycle a becomes 0; wrap_cnt = 1.
- Load 5, mode = 1, en for 7 cycles -> a = 4,3,2,1,0,30,29; wrap_cnt = 1; sel_err = 0.
- Load 31 -> a = 30, load_clamped pulses for 1 cycle, wrap_cnt = 0.
- At a = 12, force sel = 2'b10 with mode = 0 -> a = 0, wrap_pulse = 1, sel_err = 1 and stays 1 until reset.
- sel = 2'b11 with en = 1 at a = 7 -> a stays 7, sel_err = 1. The same stimulus with en = 0 leaves sel_err = 0.
- Assert rst_n low between clock edges at a = 17 -> a = 0 immediately. Run 300 wraps -> wrap_cnt saturates at 255.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for the mod-31 up/down counter.
// Used by the datapath and the boundary detector.
package cnt_pkg;

  localparam logic [1:0] SEL_WRAP = 2'b10;
  localparam logic [1:0] SEL_STEP = 2'b01;

  localparam int MAXV_DEF = 30;

  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

  function automatic logic sel_legal(
    input logic [1:0] s
  );
    return (s == SEL_WRAP) || (s == SEL_STEP);
  endfunction

endpackage

// File: rtl/cnt_next.sv
// Combinational next count and expected select
// for the mod-31 counter datapath.
module cnt_next
  import cnt_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int MAXV  = MAXV_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a_nxt,
  output logic [1:0]       exp_sel,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] MAXV_W = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic at_end;

  // Locally derived select; out-of-range counts are treated as a step.
  always_comb begin
    at_end  = ((mode == MODE_UP) && (a == MAXV_W)) ||
              ((mode == MODE_DN) && (a == '0));
    exp_sel = at_end ? SEL_WRAP : SEL_STEP;
  end

  // Next value obeys the incoming select, even when it is wrong.
  always_comb begin
    a_nxt   = a;
    wrap    = 1'b0;
    illegal = !sel_legal(sel);
    unique case (1'b1)
      (sel == SEL_WRAP): begin
        a_nxt = (mode == MODE_DN) ? MAXV_W : '0;
        wrap  = 1'b1;
      end
      (sel == SEL_STEP): begin
        a_nxt = (mode == MODE_DN) ? a - ONE : a + ONE;
      end
      default: begin
        a_nxt = a;
      end
    endcase
  end

endmodule

// File: rtl/cnt_datapath.sv
// Registered datapath of the mod-31 up/down counter:
// count, wrap pulse/counter, load clamp and select checking.
module cnt_datapath
  import cnt_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int MAXV   = MAXV_DEF,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [1:0]        sel,
  output logic [WIDTH-1:0]  a,
  output logic              wrap_pulse,
  output logic [WCNT_W-1:0] wrap_cnt,
  output logic              sel_err,
  output logic              load_clamped
);

  localparam logic [WIDTH-1:0]  MAXV_W = WIDTH'(MAXV);
  localparam logic [WCNT_W-1:0] W_ONE  = WCNT_W'(1);

  logic [WIDTH-1:0]  a_q, a_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              clamp_q, clamp_d;

  logic [WIDTH-1:0]  a_nxt;
  logic [1:0]        exp_sel;
  logic              nxt_wrap;
  logic              nxt_illegal;

  cnt_next #(
    .WIDTH (WIDTH),
    .MAXV  (MAXV)
  ) u_next (
    .a       (a_q),
    .mode    (mode),
    .sel     (sel),
    .a_nxt   (a_nxt),
    .exp_sel (exp_sel),
    .wrap    (nxt_wrap),
    .illegal (nxt_illegal)
  );

  // Next-state: load beats enable beats hold.
  always_comb begin
    a_d     = a_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    clamp_d = 1'b0;
    if (load) begin
      clamp_d = (load_val > MAXV_W);
      a_d     = clamp_d ? MAXV_W : load_val;
      wcnt_d  = '0;
    end else if (en) begin
      a_d = a_nxt;
      if (nxt_wrap) begin
        wrap_d = 1'b1;
        if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + W_ONE;
        end
      end
      if ((sel != exp_sel) || nxt_illegal) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      clamp_q <= clamp_d;
    end
  end

  assign a            = a_q;
  assign wrap_pulse   = wrap_q;
  assign wrap_cnt     = wcnt_q;
  assign sel_err      = err_q;
  assign load_clamped = clamp_q;

endmodule
